// File: rtl/pcie_tlp_tx_arbiter.sv
// PCIe TL transmit scheduler: round-robin P/NP/CPL arbitration with
// per-type header/data flow-control credit accounting.
module pcie_tlp_tx_arbiter #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int CREDIT_DEPTH    = 12,
  parameter int HDR_CRED_W      = 8,
  parameter int HDR_CRED_INIT   = 32,
  parameter int DATA_CRED_INIT  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   src_valid,
  output logic [2:0]                   src_ready,
  input  logic [3*PIPE_DATA_WIDTH-1:0] src_data,
  input  logic [2:0]                   src_last,
  input  logic [3*CREDIT_DEPTH-1:0]    src_dcred,
  output logic                         tlp_valid,
  input  logic                         tlp_ready,
  output logic [PIPE_DATA_WIDTH-1:0]   tlp_data,
  output logic                         tlp_last,
  output logic [1:0]                   tlp_src,
  input  logic                         crd_upd_valid,
  input  logic [1:0]                   crd_upd_type,
  input  logic [HDR_CRED_W-1:0]        crd_upd_hdr,
  input  logic [CREDIT_DEPTH-1:0]      crd_upd_data,
  output logic [3*HDR_CRED_W-1:0]      hdr_cred,
  output logic [3*CREDIT_DEPTH-1:0]    data_cred
);

  localparam int W  = PIPE_DATA_WIDTH;
  localparam int CD = CREDIT_DEPTH;
  localparam int HW = HDR_CRED_W;
  localparam logic [HW:0] H_ONE = (HW+1)'(1);

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic [HW-1:0] hdr_q [3];
  logic [HW-1:0] hdr_d [3];
  logic [CD-1:0] dat_q [3];
  logic [CD-1:0] dat_d [3];

  logic [3:0]    elig;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;
  logic [1:0]    scan;
  logic          grant;
  logic [HW:0]   h_sum;
  logic [CD:0]   d_sum;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        hdr_q[i] <= HW'(HDR_CRED_INIT);
        dat_q[i] <= CD'(DATA_CRED_INIT);
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      for (int i = 0; i < 3; i++) begin
        hdr_q[i] <= hdr_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // A source may start only if one header and all its data credits fit.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 3; i++) begin
      elig[i] = src_valid[i]
             && (hdr_q[i] != '0)
             && (dat_q[i] >= src_dcred[i*CD +: CD]);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_ptr_q;
    scan    = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      if (!gnt_vld && elig[scan]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan;
      end
      scan = rr_next(scan);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    grant    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          grant   = 1'b1;
          sel_d   = gnt_idx;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (tlp_valid && tlp_ready && tlp_last) begin
          state_d  = S_IDLE;
          rr_ptr_d = rr_next(sel_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Consume is bounded by eligibility, so only the top end can overflow.
  always_comb begin
    h_sum = '0;
    d_sum = '0;
    for (int i = 0; i < 3; i++) begin
      h_sum = {1'b0, hdr_q[i]};
      d_sum = {1'b0, dat_q[i]};
      if (grant && (sel_d == 2'(i))) begin
        h_sum = h_sum - H_ONE;
        d_sum = d_sum - {1'b0, src_dcred[i*CD +: CD]};
      end
      if (crd_upd_valid && (crd_upd_type == 2'(i))) begin
        h_sum = h_sum + {1'b0, crd_upd_hdr};
        d_sum = d_sum + {1'b0, crd_upd_data};
      end
      hdr_d[i] = h_sum[HW] ? '1 : h_sum[HW-1:0];
      dat_d[i] = d_sum[CD] ? '1 : d_sum[CD-1:0];
    end
  end

  always_comb begin
    tlp_valid = 1'b0;
    tlp_last  = 1'b0;
    tlp_data  = '0;
    src_ready = '0;
    tlp_src   = sel_q;
    if (state_q == S_XFER) begin
      unique case (sel_q)
        2'd1: begin
          tlp_valid = src_valid[1];
          tlp_last  = src_last[1];
          tlp_data  = src_data[W +: W];
          src_ready = {1'b0, tlp_ready, 1'b0};
        end
        2'd2: begin
          tlp_valid = src_valid[2];
          tlp_last  = src_last[2];
          tlp_data  = src_data[2*W +: W];
          src_ready = {tlp_ready, 2'b00};
        end
        default: begin
          tlp_valid = src_valid[0];
          tlp_last  = src_last[0];
          tlp_data  = src_data[0 +: W];
          src_ready = {2'b00, tlp_ready};
        end
      endcase
    end
  end

  always_comb begin
    hdr_cred  = '0;
    data_cred = '0;
    for (int i = 0; i < 3; i++) begin
      hdr_cred[i*HW +: HW]  = hdr_q[i];
      data_cred[i*CD +: CD] = dat_q[i];
    end
  end

endmodule

// File: tb/tb_pcie_tlp_tx_arbiter.sv
// Directed bench for pcie_tlp_tx_arbiter: cycle vector table plus
// hand sequences for credit stall, saturation and mid-TLP reset.
module tb_pcie_tlp_tx_arbiter;

  localparam int W  = 256;
  localparam int CD = 12;
  localparam int HW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      src_valid;
  logic [2:0]      src_ready;
  logic [3*W-1:0]  src_data;
  logic [2:0]      src_last;
  logic [3*CD-1:0] src_dcred;
  logic            tlp_valid;
  logic            tlp_ready;
  logic [W-1:0]    tlp_data;
  logic            tlp_last;
  logic [1:0]      tlp_src;
  logic            crd_upd_valid;
  logic [1:0]      crd_upd_type;
  logic [HW-1:0]   crd_upd_hdr;
  logic [CD-1:0]   crd_upd_data;
  logic [3*HW-1:0] hdr_cred;
  logic [3*CD-1:0] data_cred;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcie_tlp_tx_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_data      (src_data),
    .src_last      (src_last),
    .src_dcred     (src_dcred),
    .tlp_valid     (tlp_valid),
    .tlp_ready     (tlp_ready),
    .tlp_data      (tlp_data),
    .tlp_last      (tlp_last),
    .tlp_src       (tlp_src),
    .crd_upd_valid (crd_upd_valid),
    .crd_upd_type  (crd_upd_type),
    .crd_upd_hdr   (crd_upd_hdr),
    .crd_upd_data  (crd_upd_data),
    .hdr_cred      (hdr_cred),
    .data_cred     (data_cred)
  );

  typedef struct {
    logic [2:0] vld;
    logic [2:0] lst;
    int         dc0;
    int         dc1;
    int         dc2;
    logic       rdy;
    int         tag;
    logic       etv;
    logic [2:0] esr;
    logic       etl;
    logic [1:0] ets;
    logic       ec;
    int         ety;
    int         eh;
    int         ed;
  } vec_t;

  vec_t tq[$];

  function automatic vec_t v(
    input logic [2:0] vld, input logic [2:0] lst,
    input int dc0, input int dc1, input int dc2,
    input logic rdy, input int tag,
    input logic etv, input logic [2:0] esr,
    input logic etl, input logic [1:0] ets,
    input logic ec, input int ety,
    input int eh, input int ed);
    vec_t r;
    r.vld = vld; r.lst = lst;
    r.dc0 = dc0; r.dc1 = dc1; r.dc2 = dc2;
    r.rdy = rdy; r.tag = tag;
    r.etv = etv; r.esr = esr;
    r.etl = etl; r.ets = ets;
    r.ec = ec; r.ety = ety;
    r.eh = eh; r.ed = ed;
    return r;
  endfunction

  function automatic logic [W-1:0] mkd(input int s, input int tag);
    return {16{4'hC, 2'b00, 2'(s), 8'(tag)}};
  endfunction

  function automatic int hc(input int t);
    return int'(hdr_cred[t*HW +: HW]);
  endfunction

  function automatic int dcr(input int t);
    return int'(data_cred[t*CD +: CD]);
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_data(input int tag);
    for (int s = 0; s < 3; s++) src_data[s*W +: W] = mkd(s, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_valid = '0; src_last = '0; src_dcred = '0;
    tlp_ready = 1'b0; crd_upd_valid = 1'b0;
    crd_upd_type = '0; crd_upd_hdr = '0; crd_upd_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at a negedge with the TLP delivered.
  task automatic send1(input int s, input int d);
    logic hit;
    hit = 1'b0;
    src_valid = 3'b001 << s;
    src_last  = 3'b001 << s;
    src_dcred = '0;
    src_dcred[s*CD +: CD] = CD'(d);
    tlp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (tlp_valid && tlp_last && tlp_src == 2'(s)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("send1_src%0d_done", s), W'(hit), W'(1));
    @(negedge clk);
    src_valid = '0;
    src_last  = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p_n;
    int c_n;
    logic hit;

    rst_n = 1'b0;
    src_valid = '0; src_last = '0; src_dcred = '0; src_data = '0;
    tlp_ready = 1'b0; crd_upd_valid = 1'b0;
    crd_upd_type = '0; crd_upd_hdr = '0; crd_upd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_tlp_valid", W'(tlp_valid), W'(0));
    chk("rst_src_ready", W'(src_ready), W'(0));
    chk("rst_tlp_data", tlp_data, '0);
    for (int t = 0; t < 3; t++) begin
      chk($sformatf("rst_hdr%0d", t), W'(hc(t)), W'(32));
      chk($sformatf("rst_dat%0d", t), W'(dcr(t)), W'(256));
    end

    // 2-beat P, single CPL, RR rotation, backpressure and bubble
    tq.push_back(v(3'b001,3'b000,4,0,0,1,1,  0,3'b000,0,0, 1,0,32,256));
    tq.push_back(v(3'b001,3'b000,4,0,0,1,1,  1,3'b001,0,0, 1,0,31,252));
    tq.push_back(v(3'b001,3'b001,4,0,0,1,2,  1,3'b001,1,0, 1,0,31,252));
    tq.push_back(v(3'b100,3'b100,0,0,2,1,3,  0,3'b000,0,0, 1,1,32,256));
    tq.push_back(v(3'b100,3'b100,0,0,2,1,3,  1,3'b100,1,2, 1,2,31,254));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,5,  0,3'b000,0,2, 1,1,32,256));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,6,  1,3'b001,1,0, 1,0,30,251));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,7,  0,3'b000,0,0, 0,0,0,0));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,8,  1,3'b010,1,1, 1,1,31,256));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,9,  0,3'b000,0,1, 0,0,0,0));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,10, 1,3'b100,1,2, 1,2,30,253));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,11, 0,3'b000,0,2, 0,0,0,0));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,12, 1,3'b001,1,0, 1,0,29,250));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,13, 0,3'b000,0,0, 0,0,0,0));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,14, 1,3'b010,1,1, 1,1,30,256));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,15, 0,3'b000,0,1, 0,0,0,0));
    tq.push_back(v(3'b111,3'b111,1,0,1,1,16, 1,3'b100,1,2, 1,2,29,252));
    tq.push_back(v(3'b001,3'b001,0,0,0,0,17, 0,3'b000,0,2, 0,0,0,0));
    tq.push_back(v(3'b001,3'b001,0,0,0,0,18, 1,3'b000,1,0, 1,0,28,250));
    tq.push_back(v(3'b000,3'b000,0,0,0,1,19, 0,3'b001,0,0, 0,0,0,0));
    tq.push_back(v(3'b001,3'b001,0,0,0,1,20, 1,3'b001,1,0, 1,0,28,250));
    tq.push_back(v(3'b000,3'b000,0,0,0,1,21, 0,3'b000,0,0, 1,2,29,252));

    foreach (tq[i]) begin
      @(negedge clk);
      src_valid = tq[i].vld;
      src_last  = tq[i].lst;
      src_dcred = {CD'(tq[i].dc2), CD'(tq[i].dc1), CD'(tq[i].dc0)};
      tlp_ready = tq[i].rdy;
      set_data(tq[i].tag);
      #1;
      chk($sformatf("v%0d_tlp_valid", i), W'(tlp_valid), W'(tq[i].etv));
      chk($sformatf("v%0d_src_ready", i), W'(src_ready), W'(tq[i].esr));
      chk($sformatf("v%0d_tlp_last", i), W'(tlp_last), W'(tq[i].etl));
      chk($sformatf("v%0d_tlp_src", i), W'(tlp_src), W'(tq[i].ets));
      if (tq[i].etv)
        chk($sformatf("v%0d_tlp_data", i), tlp_data,
            mkd(int'(tq[i].ets), tq[i].tag));
      else if (tq[i].esr == 3'b000)
        chk($sformatf("v%0d_idle_data", i), tlp_data, '0);
      if (tq[i].ec) begin
        chk($sformatf("v%0d_hdr%0d", i, tq[i].ety),
            W'(hc(tq[i].ety)), W'(tq[i].eh));
        chk($sformatf("v%0d_dat%0d", i, tq[i].ety),
            W'(dcr(tq[i].ety)), W'(tq[i].ed));
      end
    end

    // CPL starved of data credits until a return makes it fit
    do_reset();
    send1(2, 253);
    chk("t3_cpl_dat_3", W'(dcr(2)), W'(3));
    src_valid = 3'b101;
    src_last  = 3'b101;
    src_dcred = {CD'(4), CD'(0), CD'(1)};
    tlp_ready = 1'b1;
    p_n = 0;
    c_n = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (tlp_valid && tlp_src == 2'd0) p_n++;
      if (tlp_valid && tlp_src == 2'd2) c_n++;
      @(negedge clk);
    end
    chk("t3_p_beats", W'(p_n), W'(3));
    chk("t3_cpl_beats", W'(c_n), W'(0));
    chk("t3_cpl_dat_held", W'(dcr(2)), W'(3));
    crd_upd_valid = 1'b1;
    crd_upd_type  = 2'd2;
    crd_upd_hdr   = '0;
    crd_upd_data  = CD'(1);
    @(negedge clk);
    crd_upd_valid = 1'b0;
    p_n = 0;
    hit = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (tlp_valid && tlp_src == 2'd2) begin
        hit = 1'b1;
        break;
      end
      if (tlp_valid && tlp_src == 2'd0) p_n++;
      @(negedge clk);
    end
    chk("t3_cpl_granted", W'(hit), W'(1));
    chk("t3_p_between", W'(p_n), W'(1));
    chk("t3_cpl_dat_0", W'(dcr(2)), W'(0));
    src_valid = 3'b100;
    @(negedge clk);
    src_valid = '0;
    src_last  = '0;

    // NP grant coinciding with an NP header return
    do_reset();
    for (int n = 0; n < 27; n++) send1(1, 0);
    chk("t4_np_hdr_5", W'(hc(1)), W'(5));
    src_valid = 3'b010;
    src_last  = 3'b010;
    src_dcred = '0;
    tlp_ready = 1'b1;
    crd_upd_valid = 1'b1;
    crd_upd_type  = 2'd1;
    crd_upd_hdr   = HW'(2);
    crd_upd_data  = '0;
    @(negedge clk);
    crd_upd_valid = 1'b0;
    #1;
    chk("t4_np_hdr_6", W'(hc(1)), W'(6));
    chk("t4_np_dat", W'(dcr(1)), W'(256));
    chk("t4_np_xfer", W'({tlp_valid, tlp_src}), W'({1'b1, 2'd1}));
    @(negedge clk);
    src_valid = '0;
    src_last  = '0;

    // saturation at all-ones and ignored type 3
    do_reset();
    crd_upd_valid = 1'b1;
    crd_upd_type  = 2'd0;
    crd_upd_hdr   = '0;
    crd_upd_data  = CD'(3744);
    @(negedge clk);
    #1;
    chk("t5_p_dat_4000", W'(dcr(0)), W'(4000));
    crd_upd_hdr  = HW'(255);
    crd_upd_data = CD'(12'hFFF);
    @(negedge clk);
    #1;
    chk("t5_p_dat_sat", W'(dcr(0)), W'(4095));
    chk("t5_p_hdr_sat", W'(hc(0)), W'(255));
    crd_upd_type = 2'd3;
    crd_upd_hdr  = HW'(5);
    crd_upd_data = CD'(5);
    @(negedge clk);
    crd_upd_valid = 1'b0;
    #1;
    chk("t5_t3_p_hdr", W'(hc(0)), W'(255));
    chk("t5_t3_p_dat", W'(dcr(0)), W'(4095));
    for (int t = 1; t < 3; t++) begin
      chk($sformatf("t5_t3_hdr%0d", t), W'(hc(t)), W'(32));
      chk($sformatf("t5_t3_dat%0d", t), W'(dcr(t)), W'(256));
    end

    // reset in the middle of a 4-beat CPL under toggling ready
    do_reset();
    send1(0, 0);
    src_valid = 3'b100;
    src_last  = 3'b000;
    src_dcred = {CD'(8), CD'(0), CD'(0)};
    for (int k = 0; k < 5; k++) begin
      tlp_ready = (k % 2 == 1);
      @(negedge clk);
    end
    #1;
    chk("t6_mid_src", W'(tlp_src), W'(2));
    chk("t6_mid_valid", W'(tlp_valid), W'(1));
    chk("t6_mid_cpl_dat", W'(dcr(2)), W'(248));
    rst_n = 1'b0;
    tlp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_valid", W'(tlp_valid), W'(0));
    chk("t6_rst_ready", W'(src_ready), W'(0));
    chk("t6_rst_last", W'(tlp_last), W'(0));
    chk("t6_rst_src", W'(tlp_src), W'(0));
    chk("t6_rst_data", tlp_data, '0);
    chk("t6_rst_hdr2", W'(hc(2)), W'(32));
    chk("t6_rst_dat2", W'(dcr(2)), W'(256));
    chk("t6_rst_hdr0", W'(hc(0)), W'(32));
    @(negedge clk);
    rst_n = 1'b1;
    src_valid = 3'b111;
    src_last  = 3'b111;
    src_dcred = '0;
    #1;
    chk("t6_idle_valid", W'(tlp_valid), W'(0));
    @(negedge clk);
    #1;
    chk("t6_first_grant", W'({tlp_valid, tlp_src}), W'({1'b1, 2'd0}));
    @(negedge clk);
    src_valid = '0;
    src_last  = '0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
